// File: rtl/elevator_pkg.sv
// Shared types and default sizes for the elevator call panel.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2,
    EMERG = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_call_panel_if.sv
// Panel <-> elevator core signal bundle; master is the call panel.
interface elevator_call_panel_if #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W
);
  logic [NUM_FLOORS-1:0] btn;
  logic                  estop_btn;
  logic [FLOOR_W-1:0]    floor;
  logic                  door;
  logic [FLOOR_W-1:0]    call;
  logic                  call_valid;
  logic                  emergency;
  logic [NUM_FLOORS-1:0] pending;
  logic                  timeout;

  modport master (
    input  btn, estop_btn, floor, door,
    output call, call_valid, emergency, pending, timeout
  );

  modport slave (
    output btn, estop_btn, floor, door,
    input  call, call_valid, emergency, pending, timeout
  );
endinterface

// File: rtl/elevator_target_sel.sv
// SCAN target picker: current floor first, then nearest ahead, then nearest behind (flip).
module elevator_target_sel #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  sweep_up,
  output logic                  cand_valid,
  output logic [FLOOR_W-1:0]    cand_floor,
  output logic                  cand_flip
);
  import elevator_pkg::*;

  int                 fl_i;
  logic               up_found;
  logic [FLOOR_W-1:0] up_floor;
  logic               dn_found;
  logic [FLOOR_W-1:0] dn_floor;

  // Descending scan above / ascending scan below leaves the nearest hit last.
  always_comb begin
    fl_i     = int'(floor);
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (i > fl_i)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (i < fl_i)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    cand_valid = 1'b0;
    cand_floor = '0;
    cand_flip  = 1'b0;
    if (fl_i < int'(NUM_FLOORS)) begin
      if (pending[floor]) begin
        cand_valid = 1'b1;
        cand_floor = floor;
      end else if (sweep_up == DIR_UP) begin
        if (up_found) begin
          cand_valid = 1'b1;
          cand_floor = up_floor;
        end else if (dn_found) begin
          cand_valid = 1'b1;
          cand_floor = dn_floor;
          cand_flip  = 1'b1;
        end
      end else begin
        if (dn_found) begin
          cand_valid = 1'b1;
          cand_floor = dn_floor;
        end else if (up_found) begin
          cand_valid = 1'b1;
          cand_floor = up_floor;
          cand_flip  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches floor presses, SCAN-schedules calls, drives emergency stop.
// Optional SERVE watchdog enabled by defining PANEL_TIMEOUT_EN.
module elevator_call_panel #(
  parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W,
  parameter int unsigned DOOR_HOLD  = 3
`ifdef PANEL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  elevator_call_panel_if.master bus
);
  import elevator_pkg::*;

  localparam int unsigned HOLD_W = (DOOR_HOLD > 2) ? $clog2(DOOR_HOLD) : 1;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] btn_q, btn_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    call_q, call_d;
  logic                  call_valid_q, call_valid_d;
  logic                  emergency_q, emergency_d;
  logic                  timeout_q, timeout_d;
  logic                  sweep_up_q, sweep_up_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] drop;
  logic                  floor_ok;
  logic                  at_call;
  logic                  retarget;
  logic                  cand_valid;
  logic [FLOOR_W-1:0]    cand_floor;
  logic                  cand_flip;

`ifdef PANEL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  elevator_target_sel #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_target_sel (
    .pending    (pending_q),
    .floor      (bus.floor),
    .sweep_up   (sweep_up_q),
    .cand_valid (cand_valid),
    .cand_floor (cand_floor),
    .cand_flip  (cand_flip)
  );

  // Press edges, door-open clears, and the retarget window.
  always_comb begin
    floor_ok = ({1'b0, bus.floor} < (FLOOR_W+1)'(NUM_FLOORS));
    press    = bus.btn & ~btn_q;
    btn_d    = bus.btn;
    clr      = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      clr[i] = bus.door && floor_ok && (state_q != EMERG) && (bus.floor == FLOOR_W'(i));
    end
    at_call  = floor_ok && bus.door && (bus.floor == call_q);
    if (sweep_up_q == DIR_UP) begin
      retarget = cand_valid && floor_ok && (cand_floor > bus.floor) && (cand_floor < call_q);
    end else begin
      retarget = cand_valid && floor_ok && (cand_floor < bus.floor) && (cand_floor > call_q);
    end
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d      = state_q;
    call_d       = call_q;
    call_valid_d = 1'b0;
    emergency_d  = 1'b0;
    timeout_d    = 1'b0;
    sweep_up_d   = sweep_up_q;
    hold_cnt_d   = hold_cnt_q;
    drop         = '0;
`ifdef PANEL_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          call_d       = cand_floor;
          call_valid_d = 1'b1;
          state_d      = SERVE;
          if (cand_flip) sweep_up_d = (sweep_up_q == DIR_UP) ? DIR_DOWN : DIR_UP;
`ifdef PANEL_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      SERVE: begin
        call_valid_d = 1'b1;
`ifdef PANEL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
`endif
        if (at_call) begin
          call_valid_d = 1'b0;
          hold_cnt_d   = HOLD_W'(DOOR_HOLD - 1);
          state_d      = HOLD;
        end else if (!pending_q[call_q]) begin
          call_valid_d = 1'b0;
          state_d      = IDLE;
`ifdef PANEL_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          call_valid_d = 1'b0;
          timeout_d    = 1'b1;
          drop[call_q] = 1'b1;
          state_d      = IDLE;
`endif
        end else if (retarget) begin
          call_d       = cand_floor;
`ifdef PANEL_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      EMERG: begin
        emergency_d = 1'b1;
        if (!bus.estop_btn) begin
          emergency_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Emergency stop overrides everything; call and sweep are frozen.
    if (bus.estop_btn) begin
      state_d      = EMERG;
      emergency_d  = 1'b1;
      call_valid_d = 1'b0;
      timeout_d    = 1'b0;
      call_d       = call_q;
      sweep_up_d   = sweep_up_q;
      drop         = '0;
    end

    pending_d = (pending_q | press) & ~clr & ~drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      btn_q        <= '0;
      pending_q    <= '0;
      call_q       <= '0;
      call_valid_q <= 1'b0;
      emergency_q  <= 1'b0;
      timeout_q    <= 1'b0;
      sweep_up_q   <= DIR_UP;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      btn_q        <= btn_d;
      pending_q    <= pending_d;
      call_q       <= call_d;
      call_valid_q <= call_valid_d;
      emergency_q  <= emergency_d;
      timeout_q    <= timeout_d;
      sweep_up_q   <= sweep_up_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

`ifdef PANEL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign bus.call       = call_q;
  assign bus.call_valid = call_valid_q;
  assign bus.emergency  = emergency_q;
  assign bus.pending    = pending_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed vector bench for elevator_call_panel; timeout sequence follows PANEL_TIMEOUT_EN.
module tb_elevator_call_panel;

  logic clk = 1'b0;
  logic rst = 1'b1;

  elevator_call_panel_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_call_panel dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         pre_rst;
    logic [3:0] btn;
    logic       estop;
    logic [1:0] floor;
    logic       door;
    logic [1:0] e_call;
    logic       e_cv;
    logic       e_em;
    logic [3:0] e_pend;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] b, input logic e, input logic [1:0] f, input logic d);
    bus.btn       = b;
    bus.estop_btn = e;
    bus.floor     = f;
    bus.door      = d;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [3:0] b, logic e, logic [1:0] f, logic d,
                              logic [1:0] c, logic cv, logic em, logic [3:0] p);
    vec_t v;
    v.pre_rst = r; v.btn = b; v.estop = e; v.floor = f; v.door = d;
    v.e_call = c; v.e_cv = cv; v.e_em = em; v.e_pend = p;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int first_pulse;
    int pulses;

    // Single press, serve, 3-cycle hold measured by the next pick
    vecs.push_back(mk(1, 4'b0000, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 0, 2'd0, 0, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 0, 2'd2, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 1, 2'd2, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, 0, 2'd2, 1, 2'd2, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 0, 2'd2, 1, 2'd2, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 0, 2'd2, 0, 2'd2, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 0, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 0, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 1, 2'd0, 0, 0, 4'b0000));
    // SCAN order from floor 1 going up, then reversal and downward retarget
    vecs.push_back(mk(1, 4'b1001, 0, 2'd1, 0, 2'd0, 0, 0, 4'b1001));
    vecs.push_back(mk(0, 4'b1001, 0, 2'd1, 0, 2'd3, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 0, 2'd3, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 1, 2'd3, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 0, 2'd3, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 0, 2'd3, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 0, 2'd3, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd3, 0, 2'd0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0010, 0, 2'd2, 0, 2'd0, 1, 0, 4'b0011));
    vecs.push_back(mk(0, 4'b0010, 0, 2'd2, 0, 2'd1, 1, 0, 4'b0011));
    // Upward retarget to a floor pressed en route
    vecs.push_back(mk(1, 4'b1000, 0, 2'd0, 0, 2'd0, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b1000, 0, 2'd0, 0, 2'd3, 1, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b1100, 0, 2'd0, 0, 2'd3, 1, 0, 4'b1100));
    vecs.push_back(mk(0, 4'b1100, 0, 2'd0, 0, 2'd2, 1, 0, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 0, 2'd2, 1, 0, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd2, 1, 2'd2, 0, 0, 4'b1000));
    // Emergency stop: pending kept, presses latched, no clear, resume after release
    vecs.push_back(mk(1, 4'b0010, 0, 2'd0, 0, 2'd0, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0010, 0, 2'd0, 0, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 1, 2'd0, 0, 2'd1, 0, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b0100, 1, 2'd1, 1, 2'd1, 0, 1, 4'b0110));
    vecs.push_back(mk(0, 4'b0100, 0, 2'd0, 0, 2'd1, 0, 0, 4'b0110));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 2'd1, 1, 0, 4'b0110));
    // Press/clear collision, held button, current-floor pick
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 2'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0010, 0, 2'd1, 0, 2'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 0, 2'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0010, 0, 2'd1, 0, 2'd0, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 0, 2'd1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 1, 2'd1, 0, 0, 4'b0000));

    drive(4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #12;
    chk("rst_call",    -1, 32'(bus.call), 32'd0);
    chk("rst_valid",   -1, 32'(bus.call_valid), 32'd0);
    chk("rst_emerg",   -1, 32'(bus.emergency), 32'd0);
    chk("rst_pending", -1, 32'(bus.pending), 32'd0);
    chk("rst_timeout", -1, 32'(bus.timeout), 32'd0);
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      drive(vecs[i].btn, vecs[i].estop, vecs[i].floor, vecs[i].door);
      step();
      chk("call",       i, 32'(bus.call),       32'(vecs[i].e_call));
      chk("call_valid", i, 32'(bus.call_valid), 32'(vecs[i].e_cv));
      chk("emergency",  i, 32'(bus.emergency),  32'(vecs[i].e_em));
      chk("pending",    i, 32'(bus.pending),    32'(vecs[i].e_pend));
      chk("timeout",    i, 32'(bus.timeout),    32'd0);
    end

    // Asynchronous reset in the middle of a SERVE
    do_reset();
    drive(4'b0100, 1'b0, 2'd0, 1'b0);
    step();
    step();
    chk("mid_pre_valid", 100, 32'(bus.call_valid), 32'd1);
    chk("mid_pre_call",  100, 32'(bus.call), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_call",    101, 32'(bus.call), 32'd0);
    chk("mid_rst_valid",   101, 32'(bus.call_valid), 32'd0);
    chk("mid_rst_pending", 101, 32'(bus.pending), 32'd0);
    chk("mid_rst_emerg",   101, 32'(bus.emergency), 32'd0);
    #1;
    rst = 1'b0;

    // Car stuck at floor 0 with a call to floor 3
    do_reset();
    drive(4'b1000, 1'b0, 2'd0, 1'b0);
    step();
    step();
    chk("tmo_serve_call", 200, 32'(bus.call), 32'd3);
    chk("tmo_serve_valid", 200, 32'(bus.call_valid), 32'd1);
    drive(4'b0000, 1'b0, 2'd0, 1'b0);
    first_pulse = 0;
    pulses = 0;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (bus.timeout === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = n;
      end
    end
`ifdef PANEL_TIMEOUT_EN
    chk("tmo_pulses",  201, 32'(pulses), 32'd1);
    chk("tmo_at",      201, 32'(first_pulse), 32'd16);
    chk("tmo_pending", 201, 32'(bus.pending), 32'd0);
    chk("tmo_valid",   201, 32'(bus.call_valid), 32'd0);
`else
    chk("tmo_pulses",  201, 32'(pulses), 32'd0);
    chk("tmo_pending", 201, 32'(bus.pending), 32'h8);
    chk("tmo_valid",   201, 32'(bus.call_valid), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Requester side of the elevator call interface: latches floor button presses, picks the next floor to serve, and drives `call` / `emergency` into the elevator core.
- Uses SCAN (sweep) scheduling. Watches the elevator's `floor` and `door` to decide when a request is served, then clears it.
- Sits between the button/panel inputs and the elevator core.

Parameters:
- NUM_FLOORS, 4, number of floors; floor encoding is 0..NUM_FLOORS-1.
- FLOOR_W, 2, width of floor/call codes; equals $clog2(NUM_FLOORS).
- DOOR_HOLD, 3, cycles the call is held on a served floor after door open, before the next pick.
- TIMEOUT_CYCLES, 16, SERVE-state watchdog limit; used only with PANEL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  NUM_FLOORS  floor request buttons, level; a press is the rising edge.
- estop_btn  in  1  emergency stop button, level.
- floor  in  FLOOR_W  current floor reported by the elevator core.
- door  in  1  door open from the elevator core (1 = open).
- call  out  FLOOR_W  target floor code to the elevator; registered.
- call_valid  out  1  high while a target is being served.
- emergency  out  1  emergency stop to the elevator; registered.
- pending  out  NUM_FLOORS  outstanding request bitmap.
- timeout  out  1  one-cycle fault pulse; constant 0 without PANEL_TIMEOUT_EN.

Behaviour:
- Reset (async): call=0, call_valid=0, emergency=0, pending=0, timeout=0, btn_q=0, sweep_up=1, hold_cnt=0, state=IDLE.
- Press detection:
  - btn_q registers btn; press[i] = btn[i] & ~btn_q[i].
  - Next cycle pending[i] is set, giving 1-cycle latency from the btn edge to pending.
  - A held button produces one request only.
- Clear: pending[i] clears on any cycle with door=1 and floor=i, in any state except EMERG.
  - If a press and a clear hit the same floor in the same cycle, clear wins.
- Target select (combinational, from pending, floor, sweep_up):
  1. pending[floor] set -> floor.
  2. Otherwise, nearest pending floor in the sweep direction.
  3. Otherwise, nearest pending floor in the opposite direction; sweep_up flips when that target is registered.
  4. No pending -> no candidate.
- States:
  - IDLE:
    - call_valid=0; call holds its last value so the car stays parked.
    - If a candidate exists: register call=candidate, call_valid=1, go to SERVE.
  - SERVE:
    - Each cycle, if the candidate lies strictly between floor and call in the sweep direction, call updates to it (retarget).
    - When floor==call and door=1: clear the bit, go to HOLD, load hold_cnt=DOOR_HOLD-1.
    - If pending[call] is cleared externally (served en route), go to IDLE.
  - HOLD:
    - call_valid=0, call unchanged; hold_cnt decrements.
    - At 0, go to IDLE.
  - EMERG:
    - Entered from any state on the cycle after estop_btn=1 (highest priority).
    - emergency=1, call_valid=0, pending retained, presses still latched.
    - When estop_btn is low, stay one more cycle, then emergency=0 and go to IDLE.
- call never changes while in HOLD or EMERG.
- Floors ≥NUM_FLOORS on the floor input are ignored for clear/select.
- The sweep reverses only when nothing remains in the current direction.
- Reset mid-operation drops all state immediately. The elevator then sees call=0, emergency=0.

Optional Feature:
- Macro: PANEL_TIMEOUT_EN.
- Defined:
  - A counter runs in SERVE and resets on entry or retarget.
  - On reaching TIMEOUT_CYCLES: timeout=1 for one cycle, pending[call] is dropped, state goes to IDLE.
- Undefined: no counter; timeout is tied to 0.

Decomposition:
- Package elevator_pkg:
  - state enum (IDLE, SERVE, HOLD, EMERG);
  - NUM_FLOORS and FLOOR_W defaults;
  - DIR_UP=1 and DIR_DOWN=0 constants.
- Sub-module elevator_target_sel: purely combinational; takes pending, floor, sweep_up and returns cand_valid, cand_floor, cand_flip.

Test Plan:
- Reset then single press: btn[2] edge with floor=0 -> pending=0100 next cycle; call=2 and call_valid=1 one cycle later. Drive floor=2, door=1 -> pending=0000, HOLD for 3 cycles, then call_valid=0 with call still 2.
- SCAN order: floor=1, sweep_up=1, presses at floors 0 and 3 in the same cycle -> call=3 first. After 3 is served -> call=0 and sweep_up=0.
- Retarget: serving call=3 from floor=0, press btn[2] -> call becomes 2 the cycle after pending[2] sets.
- Emergency: in SERVE, estop_btn=1 for 2 cycles -> emergency=1 next cycle, call_valid=0, pending unchanged. emergency drops one cycle after estop_btn=0, then SERVE resumes toward the same floor.
- Press/clear collision: door=1 at floor=1 while btn[1] rises -> pending[1] stays 0. A held button produces no further request.
- With PANEL_TIMEOUT_EN: call=3, floor stuck at 0 for 16 cycles -> timeout pulses once, pending[3]=0, state IDLE.
